// File: rtl/arb_mux_pkg.sv
// Shared types for the 4-channel round-robin arbiter + mux.
// Holds channel count, index type, pointer reset value, helpers.
package arb_mux_pkg;

  localparam int N_CH = 4;

  typedef logic [1:0] ch_idx_t;

  localparam ch_idx_t PTR_RST = ch_idx_t'(3);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } ostate_e;

  function automatic logic [N_CH-1:0] onehot4(input ch_idx_t i);
    return 4'b0001 << i;
  endfunction

endpackage

// File: rtl/arb_mux_4_1_rr_pick.sv
// rr_pick_4: combinational rotating-priority picker.
// Ports: req request vector, ptr last winner, grant, any.
module rr_pick_4
  import arb_mux_pkg::*;
(
  input  logic [N_CH-1:0] req,
  input  ch_idx_t         ptr,
  output ch_idx_t         grant,
  output logic            any
);

  ch_idx_t idx;
  logic    found;

  // Search ptr+1, ptr+2, ptr+3, ptr+4 (wraps mod 4).
  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 1; k <= N_CH; k++) begin
      idx = ptr + ch_idx_t'(k);
      if (!found && req[idx]) begin
        grant = idx;
        found = 1'b1;
      end
    end
    any = |req;
  end

endmodule

// File: rtl/mux_4_1.sv
// Plain 4:1 data mux.
// Ports: sel_i select, d0_i..d3_i data in, y_o selected data.
module mux_4_1 #(
  parameter int WIDTH = 4
) (
  input  logic [1:0]       sel_i,
  input  logic [WIDTH-1:0] d0_i,
  input  logic [WIDTH-1:0] d1_i,
  input  logic [WIDTH-1:0] d2_i,
  input  logic [WIDTH-1:0] d3_i,
  output logic [WIDTH-1:0] y_o
);

  always_comb begin
    y_o = d0_i;
    unique case (sel_i)
      2'd0: y_o = d0_i;
      2'd1: y_o = d1_i;
      2'd2: y_o = d2_i;
      2'd3: y_o = d3_i;
      default: y_o = d0_i;
    endcase
  end

endmodule

// File: rtl/arb_mux_4_1.sv
// Round-robin 4:1 arbiter with a one-entry registered output.
// Ports: clk, rst (sync high), in_valid/in_ready, d0..d3,
//   out_valid/out_ready, out_data, out_sel.
// ARB_MUX_4_1_FIXED_PRIO_EN: fixed priority, ch0 highest.
module arb_mux_4_1
  import arb_mux_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       in_valid,
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  input  logic [WIDTH-1:0] d3,
  output logic [3:0]       in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       out_sel,
  input  logic             out_ready
);

  ostate_e          state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  ch_idx_t          sel_q, sel_d;
  ch_idx_t          ptr_cur;
  ch_idx_t          grant;
  logic             any;
  logic             can_accept;
  logic             xfer;
  logic [WIDTH-1:0] mux_y;

`ifdef ARB_MUX_4_1_FIXED_PRIO_EN
  // Search from ptr+1 = 0 gives ch0 highest priority.
  assign ptr_cur = PTR_RST;
`else
  ch_idx_t ptr_q, ptr_d;

  assign ptr_cur = ptr_q;

  always_comb begin
    ptr_d = ptr_q;
    if (xfer) ptr_d = grant;
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= PTR_RST;
    else     ptr_q <= ptr_d;
  end
`endif

  rr_pick_4 u_pick (
    .req   (in_valid),
    .ptr   (ptr_cur),
    .grant (grant),
    .any   (any)
  );

  mux_4_1 #(.WIDTH(WIDTH)) u_mux (
    .sel_i (grant),
    .d0_i  (d0),
    .d1_i  (d1),
    .d2_i  (d2),
    .d3_i  (d3),
    .y_o   (mux_y)
  );

  assign out_valid  = (state_q == FULL);
  assign can_accept = !out_valid || out_ready;

  // Held low during reset so nothing is taken on that edge.
  assign in_ready = (can_accept && any && !rst)
                  ? onehot4(grant) : 4'b0000;

  assign xfer = |(in_valid & in_ready);

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    sel_d   = sel_q;
    unique case (state_q)
      EMPTY: begin
        if (xfer) state_d = FULL;
      end
      FULL: begin
        if (out_ready && !xfer) state_d = EMPTY;
      end
      default: state_d = EMPTY;
    endcase
    if (xfer) begin
      data_d = mux_y;
      sel_d  = grant;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      data_q  <= '0;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
    end
  end

  assign out_data = data_q;
  assign out_sel  = sel_q;

endmodule

// File: tb/tb_arb_mux_4_1.sv
// Scoreboard bench for arb_mux_4_1.
// Directed plan checks plus randomized traffic vs a reference model.
module tb_arb_mux_4_1;
  import arb_mux_pkg::*;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [3:0]   in_valid = '0;
  logic [3:0]   in_ready;
  logic [W-1:0] d0, d1, d2, d3;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic [1:0]   out_sel;
  logic         out_ready = 1'b0;

  logic [W-1:0] dat [4] = '{default: '0};

  assign d0 = dat[0];
  assign d1 = dat[1];
  assign d2 = dat[2];
  assign d3 = dat[3];

  arb_mux_4_1 #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .d0        (d0),
    .d1        (d1),
    .d2        (d2),
    .d3        (d3),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    int sel;
    int data;
  } beat_t;

  beat_t q[$];
  int    nt = 0;
  int    nf = 0;
  int    m_ptr = 3;
  bit    m_valid = 1'b0;

  task automatic check(input string nm, input int act,
                       input int exp);
    nt++;
    if (act != exp) begin
      nf++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t",
               nm, act, exp, $time);
    end
  endtask

  // Winner = first valid channel after the last winner.
  function automatic int pick(input logic [3:0] v);
    int start;
`ifdef ARB_MUX_4_1_FIXED_PRIO_EN
    start = 0;
`else
    start = (m_ptr + 1) % 4;
`endif
    for (int k = 0; k < 4; k++) begin
      if (v[(start + k) % 4]) return (start + k) % 4;
    end
    return -1;
  endfunction

  // One clock: drive, check comb outputs, advance model.
  task automatic cyc(input logic [3:0] v, input bit rdy,
                     input bit r, output int g);
    int gr;
    bit acc;
    int exp_rdy;
    in_valid  = v;
    out_ready = rdy;
    rst       = r;
    #1;
    gr  = pick(v);
    acc = !r && (!m_valid || rdy) && (gr >= 0);
    exp_rdy = acc ? (1 << gr) : 0;
    check("in_ready", int'(in_ready), exp_rdy);
    check("out_valid", int'(out_valid), int'(m_valid));
    @(posedge clk);
    g = -1;
    if (r) begin
      q.delete();
      m_valid = 1'b0;
      m_ptr   = 3;
    end else if (acc) begin
      q.push_back('{sel: gr, data: int'(dat[gr])});
      m_ptr   = gr;
      m_valid = 1'b1;
      g       = gr;
    end else if (rdy) begin
      m_valid = 1'b0;
    end
    #1;
  endtask

  // Monitor: each consumed beat must match the queue head.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (q.size() == 0) begin
        nt++;
        nf++;
        $display("FAIL sb_unexpected sel=%0d data=%0d t=%0t",
                 out_sel, out_data, $time);
      end else begin
        beat_t b;
        b = q.pop_front();
        check("sb_sel", int'(out_sel), b.sel);
        check("sb_data", int'(out_data), b.data);
      end
    end
  end

  initial begin
    int g;
    logic [3:0] pend;
    bit rdy;
    bit r;

    cyc(4'b0000, 1'b0, 1'b1, g);
    cyc(4'b0000, 1'b0, 1'b1, g);

    for (int i = 0; i < 5; i++) cyc(4'b0000, 1'b1, 1'b0, g);
    check("rst_out_sel", int'(out_sel), 0);
    check("rst_out_data", int'(out_data), 0);

    dat[0] = 4'hA; dat[1] = 4'hB;
    dat[2] = 4'hC; dat[3] = 4'hD;
    for (int i = 0; i < 8; i++) begin
      cyc(4'b1111, 1'b1, 1'b0, g);
`ifndef ARB_MUX_4_1_FIXED_PRIO_EN
      check("rr_seq_sel", int'(out_sel), i % 4);
      check("rr_seq_data", int'(out_data), 10 + i % 4);
`else
      check("fp_seq_sel", int'(out_sel), 0);
`endif
    end
    cyc(4'b0000, 1'b1, 1'b0, g);

    dat[2] = 4'h5;
    cyc(4'b0100, 1'b0, 1'b0, g);
    check("stall_valid", int'(out_valid), 1);
    check("stall_data", int'(out_data), 5);
    cyc(4'b0100, 1'b0, 1'b0, g);
    check("stall_hold", int'(out_data), 5);
    dat[2] = 4'h6;
    cyc(4'b0100, 1'b1, 1'b0, g);
    check("replace_data", int'(out_data), 6);
    cyc(4'b0000, 1'b1, 1'b0, g);

    cyc(4'b1000, 1'b1, 1'b0, g);
    check("wrap_sel3", int'(out_sel), 3);
    cyc(4'b1001, 1'b1, 1'b0, g);
    check("wrap_sel0", int'(out_sel), 0);
    cyc(4'b1001, 1'b1, 1'b0, g);
`ifndef ARB_MUX_4_1_FIXED_PRIO_EN
    check("wrap_sel3b", int'(out_sel), 3);
`else
    check("fp_sel0", int'(out_sel), 0);
`endif
    cyc(4'b0000, 1'b1, 1'b0, g);

    cyc(4'b0010, 1'b0, 1'b0, g);
    cyc(4'b0010, 1'b0, 1'b0, g);
    cyc(4'b0010, 1'b0, 1'b1, g);
    check("rst_drop_valid", int'(out_valid), 0);
    cyc(4'b1111, 1'b1, 1'b0, g);
    check("rst_first_ch0", int'(out_sel), 0);
    cyc(4'b0000, 1'b1, 1'b0, g);

`ifdef ARB_MUX_4_1_FIXED_PRIO_EN
    for (int i = 0; i < 6; i++) begin
      cyc(4'b1110, 1'b1, 1'b0, g);
      check("fp_starve", int'(out_sel), 1);
    end
    cyc(4'b0000, 1'b1, 1'b0, g);
`endif

    pend = '0;
    for (int i = 0; i < 2000; i++) begin
      for (int c = 0; c < 4; c++) begin
        if (!pend[c] && $urandom_range(0, 99) < 40) begin
          pend[c] = 1'b1;
          dat[c]  = W'($urandom);
        end
      end
      rdy = ($urandom_range(0, 3) != 0);
      r   = ($urandom_range(0, 199) == 0);
      cyc(pend, rdy, r, g);
      if (g >= 0) pend[g] = 1'b0;
    end

    for (int i = 0; i < 3; i++) cyc(4'b0000, 1'b1, 1'b0, g);
    check("sb_empty", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", nt, nf);
    $finish;
  end

endmodule
